// File: rtl/instr_rom_loader_if.sv
// Byte-stream port into the instruction ROM loader.
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready; the sender holds
// in_data/in_last stable while in_valid is high and not yet accepted; in_ready never depends on in_valid.
interface instr_rom_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/instr_rom_loader.sv
// Packs an incoming byte stream into the flat instruction ROM image read by Fetch.
// Optional LOADER_CHECKSUM_EN: the in_last byte is an 8-bit two's-complement checksum, not stored.
module instr_rom_loader #(
  parameter int ROM_BYTES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  instr_rom_loader_if.slave      bus,
  output logic [ROM_BYTES*8-1:0] instr_rom,
  output logic [31:0]            rom_size,
  output logic                   load_done,
  output logic                   load_error,
  output logic [1:0]             state_dbg
);

  localparam int AW    = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;
  localparam int PTR_W = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_inc;
  logic [AW-1:0]      wr_idx;
  logic               in_ready_q;
  logic               full;
  logic               is_data;
  logic               start_go;
  logic               store;
  logic               finish;
  logic               err_set;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         sum_q;
  logic [7:0]         cks_sum;
`endif

  assign bus.in_ready = in_ready_q;
  assign state_dbg    = state_q;
  assign wr_ptr_inc   = wr_ptr + PTR_W'(1);
  assign wr_idx       = wr_ptr[AW-1:0];
  assign full         = (wr_ptr == PTR_W'(ROM_BYTES));
`ifdef LOADER_CHECKSUM_EN
  assign cks_sum      = sum_q + bus.in_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    store    = 1'b0;
    finish   = 1'b0;
    err_set  = 1'b0;
    start_go = start && (state_q != S_LOAD);
    is_data  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    is_data  = !bus.in_last;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          // A data byte arriving with the ROM already full is dropped and ends the load.
          if (is_data && full) begin
            err_set = 1'b1;
            finish  = 1'b1;
          end else if (is_data) begin
            store  = 1'b1;
            finish = bus.in_last;
          end
`ifdef LOADER_CHECKSUM_EN
          else begin
            finish  = 1'b1;
            err_set = (cks_sum != 8'h00);
          end
`endif
          if (finish) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      instr_rom  <= '0;
      rom_size   <= '0;
      in_ready_q <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else if (start_go) begin
      wr_ptr     <= '0;
      instr_rom  <= '0;
      rom_size   <= '0;
      in_ready_q <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      if (store) begin
        instr_rom[{wr_idx, 3'b000} +: 8] <= bus.in_data;
        wr_ptr   <= wr_ptr_inc;
        rom_size <= 32'(wr_ptr_inc);
`ifdef LOADER_CHECKSUM_EN
        sum_q    <= cks_sum;
`endif
      end
      if (finish) begin
        in_ready_q <= 1'b0;
        load_done  <= 1'b1;
      end
      if (err_set) load_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_rom_loader.sv
// Bench for instr_rom_loader with an 8-byte ROM; reference model follows LOADER_CHECKSUM_EN.
module tb_instr_rom_loader;
  localparam int RB = 8;
  localparam int W  = RB * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  instr_rom;
  logic [31:0]   rom_size;
  logic          load_done;
  logic          load_error;
  logic [1:0]    state_dbg;

  instr_rom_loader_if bus ();

  instr_rom_loader #(.ROM_BYTES(RB)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .instr_rom  (instr_rom),
    .rom_size   (rom_size),
    .load_done  (load_done),
    .load_error (load_error),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] exp_q[$];
  logic         hs_q     = 1'b0;
  logic [7:0]   stim[16];

  logic [W-1:0] mdl_img;
  int           mdl_size;
  bit           mdl_err;
  bit           mdl_done;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   mdl_sum;
`endif

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: each accepted byte pops the rom_size expected after that edge
  always @(posedge clk) hs_q <= bus.in_valid && bus.in_ready;

  always @(negedge clk) begin
    if (hs_q) begin
      if (exp_q.size() == 0) check("sb_unexpected_hs", W'(exp_q.size()), W'(1));
      else                   check("rom_size_step", W'(rom_size), exp_q.pop_front());
    end
  end

  task automatic chk_idle_outputs(input string pfx);
    check({pfx, "_rom"},   instr_rom,          '0);
    check({pfx, "_size"},  W'(rom_size),       '0);
    check({pfx, "_ready"}, W'(bus.in_ready),   '0);
    check({pfx, "_done"},  W'(load_done),      '0);
    check({pfx, "_err"},   W'(load_error),     '0);
    check({pfx, "_state"}, W'(state_dbg),      '0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdl_img  = '0;
    mdl_size = 0;
    mdl_err  = 1'b0;
    mdl_done = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    mdl_sum  = 8'h00;
`endif
    check("start_ready", W'(bus.in_ready), W'(1));
    check("start_rom",   instr_rom,        '0);
    check("start_done",  W'(load_done),    '0);
    check("start_err",   W'(load_error),   '0);
  endtask

  // Drives stim[0..n-1]; gap idle cycles (with a stray start pulse) precede each byte.
  task automatic send(input int n, input bit last, input int gap);
    logic [7:0] b;
    bit         is_last;
    int         cnt;
    for (int i = 0; i < n; i++) begin
      b       = stim[i];
      is_last = last && (i == n - 1);
`ifdef LOADER_CHECKSUM_EN
      if (is_last) begin
        if (8'(mdl_sum + b) != 8'h00) mdl_err = 1'b1;
        mdl_done = 1'b1;
      end else
`endif
      if (mdl_size == RB) begin
        mdl_err  = 1'b1;
        mdl_done = 1'b1;
      end else begin
        mdl_img[mdl_size*8 +: 8] = b;
        mdl_size++;
`ifdef LOADER_CHECKSUM_EN
        mdl_sum = mdl_sum + b;
`endif
        if (is_last) mdl_done = 1'b1;
      end
      exp_q.push_back(W'(mdl_size));

      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = is_last;
      cnt = 0;
      while (!bus.in_ready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (!bus.in_ready) begin
        check("accept_timeout", W'(bus.in_ready), W'(1));
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (mdl_done) break;
    end
    if (mdl_done) begin
      check("final_rom",   instr_rom,        mdl_img);
      check("final_size",  W'(rom_size),     W'(mdl_size));
      check("final_done",  W'(load_done),    W'(1));
      check("final_err",   W'(load_error),   W'(mdl_err));
      check("final_ready", W'(bus.in_ready), '0);
      check("final_state", W'(state_dbg),    W'(2));
    end
  endtask

  initial begin
    int n;
    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;

    // 13 00 00 00, valid steady
    stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
    do_start();
    send(4, 1'b1, 0);
    check("addi_word", W'(instr_rom[31:0]), W'(32'h0000_0013));

    // same stream from DONE, valid low on alternate cycles, start pulses ignored in LOAD
    do_start();
    send(4, 1'b1, 1);

    // overflow: 9 data bytes, no last
    for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
    do_start();
    send(9, 1'b0, 0);

    // reset mid-load after 3 bytes, then a clean reload
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC;
    do_start();
    send(3, 1'b0, 0);
    check("partial_size", W'(rom_size), W'(3));
    #2 reset = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < RB; i++) stim[i] = 8'(8'h10 + i);
    do_start();
    send(RB, 1'b1, 0);

    // checksum-style streams
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'hFD;
    do_start();
    send(3, 1'b1, 0);
    stim[2] = 8'hFE;
    do_start();
    send(3, 1'b1, 0);
    stim[0] = 8'h00;
    do_start();
    send(1, 1'b1, 0);
    for (int i = 0; i < 9; i++) stim[i] = 8'(8'h20 + i);
    do_start();
    send(9, 1'b1, 0);

    // random streams
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, RB);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom_range(0, 255));
      do_start();
      send(n, 1'b1, $urandom_range(0, 2));
    end

    @(negedge clk);
    check("sb_drain", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
